// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer for the MIPS_32 datapath.
// One FSM steps each instruction through fetch, decode, execute/address,
// memory access and write-back, so a single ALU and a single unified memory
// port are shared across all phases. Memory accesses use a ready handshake
// with a bounded wait; an illegal opcode or an over-long wait parks the
// sequencer in a sticky TRAP state until reset.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       memReady,
    output logic       pcWrite,
    output logic [1:0] pcSrc,
    output logic       iOrD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       regWrite,
    output logic       regDst,
    output logic       memToReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [3:0] state,
    output logic       trap
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_WB_MEM   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_WB_R     = 4'd7,
        S_EXEC_I   = 4'd8,
        S_WB_I     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // The wait that would bring the counter up to MEM_TIMEOUT is the last one
    // tolerated; on that cycle the FSM leaves for TRAP instead of counting.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    state_t           cur_state;
    logic [CNT_W-1:0] wait_cnt;
    logic             trap_flag;

    // Sequencer state, memory wait counter and sticky trap flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_state <= S_FETCH;
            wait_cnt  <= '0;
            trap_flag <= 1'b0;
        end else begin
            case (cur_state)
                S_FETCH: begin
                    if (memReady) begin
                        cur_state <= S_DECODE;
                        wait_cnt  <= '0;
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        cur_state <= S_TRAP;
                        trap_flag <= 1'b1;
                        wait_cnt  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_ONE;
                    end
                end
                S_DECODE: begin
                    wait_cnt <= '0;
                    case (opcode)
                        OP_RTYPE:      cur_state <= S_EXEC_R;
                        OP_LW, OP_SW:  cur_state <= S_MEM_ADDR;
                        OP_ADDI:       cur_state <= S_EXEC_I;
                        OP_BEQ, OP_BNE: cur_state <= S_BRANCH;
                        OP_J:          cur_state <= S_JUMP;
                        default: begin
                            cur_state <= S_TRAP;
                            trap_flag <= 1'b1;
                        end
                    endcase
                end
                S_MEM_ADDR: begin
                    // Counter is cleared here so MEM_RD/MEM_WR start from zero.
                    wait_cnt <= '0;
                    if (opcode == OP_LW) begin
                        cur_state <= S_MEM_RD;
                    end else if (opcode == OP_SW) begin
                        cur_state <= S_MEM_WR;
                    end else begin
                        cur_state <= S_TRAP;
                        trap_flag <= 1'b1;
                    end
                end
                S_MEM_RD: begin
                    if (memReady) begin
                        cur_state <= S_WB_MEM;
                        wait_cnt  <= '0;
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        cur_state <= S_TRAP;
                        trap_flag <= 1'b1;
                        wait_cnt  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_ONE;
                    end
                end
                S_MEM_WR: begin
                    if (memReady) begin
                        cur_state <= S_FETCH;
                        wait_cnt  <= '0;
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        cur_state <= S_TRAP;
                        trap_flag <= 1'b1;
                        wait_cnt  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_ONE;
                    end
                end
                S_WB_MEM: begin
                    cur_state <= S_FETCH;
                    wait_cnt  <= '0;
                end
                S_EXEC_R: begin
                    cur_state <= S_WB_R;
                    wait_cnt  <= '0;
                end
                S_WB_R: begin
                    cur_state <= S_FETCH;
                    wait_cnt  <= '0;
                end
                S_EXEC_I: begin
                    cur_state <= S_WB_I;
                    wait_cnt  <= '0;
                end
                S_WB_I: begin
                    cur_state <= S_FETCH;
                    wait_cnt  <= '0;
                end
                S_BRANCH: begin
                    cur_state <= S_FETCH;
                    wait_cnt  <= '0;
                end
                S_JUMP: begin
                    cur_state <= S_FETCH;
                    wait_cnt  <= '0;
                end
                S_TRAP: begin
                    cur_state <= S_TRAP;
                    trap_flag <= 1'b1;
                    wait_cnt  <= '0;
                end
                default: begin
                    cur_state <= S_TRAP;
                    trap_flag <= 1'b1;
                    wait_cnt  <= '0;
                end
            endcase
        end
    end

    // Control word decoded from the current state; everything is held low
    // while reset is asserted so an in-flight memory request drops at once.
    always_comb begin
        pcWrite  = 1'b0;
        pcSrc    = 2'b00;
        iOrD     = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        irWrite  = 1'b0;
        regWrite = 1'b0;
        regDst   = 1'b0;
        memToReg = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ALUOp    = 2'b00;
        if (rst) begin
            case (cur_state)
                S_FETCH: begin
                    memRead = 1'b1;
                    ALUSrcB = 2'b01;
                    // IR and PC load only on the cycle the read completes.
                    irWrite = memReady;
                    pcWrite = memReady;
                end
                S_MEM_ADDR, S_EXEC_I: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEM_RD: begin
                    memRead = 1'b1;
                    iOrD    = 1'b1;
                end
                S_WB_MEM: begin
                    regWrite = 1'b1;
                    memToReg = 1'b1;
                end
                S_MEM_WR: begin
                    memWrite = 1'b1;
                    iOrD     = 1'b1;
                end
                S_EXEC_R: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                S_WB_R: begin
                    regWrite = 1'b1;
                    regDst   = 1'b1;
                end
                S_WB_I: begin
                    regWrite = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b01;
                    pcSrc   = 2'b01;
                    pcWrite = ((opcode == OP_BEQ) && zero) ||
                              ((opcode == OP_BNE) && !zero);
                end
                S_JUMP: begin
                    pcSrc   = 2'b10;
                    pcWrite = 1'b1;
                end
                default: begin
                    pcWrite = 1'b0;
                end
            endcase
        end
    end

    assign state = cur_state;
    assign trap  = trap_flag & rst;

endmodule
